// File: rtl/world_pkg.sv
// -----------------------------------------------------------------------------
// world_pkg
// Shared constants for the robot world: map geometry, cell codes, robot
// orientation codes and the renderer colour palette.
// No ports (package).
// -----------------------------------------------------------------------------
package world_pkg;

   // Map geometry as stored by the world/map store (rows 1..10, cols 1..20).
   localparam int MAP_ROWS = 10;
   localparam int MAP_COLS = 20;

   // Cell codes held in the map store; 3..6 are unused and flagged as errors.
   typedef enum logic [2:0] {
      CELL_FREE    = 3'd0,
      CELL_WALL    = 3'd1,
      CELL_BARRIER = 3'd2,
      CELL_TRASH   = 3'd7
   } cell_e;

   typedef enum logic [1:0] {
      ORIENT_N = 2'b00,
      ORIENT_S = 2'b01,
      ORIENT_E = 2'b10,
      ORIENT_W = 2'b11
   } orient_e;

   // 24-bit RGB palette, {R, G, B}.
   localparam logic [23:0] COL_BLACK     = 24'h000000;
   localparam logic [23:0] COL_GRID      = 24'h404040;
   localparam logic [23:0] COL_FREE      = 24'h202020;
   localparam logic [23:0] COL_WALL      = 24'h804000;
   localparam logic [23:0] COL_BARRIER   = 24'hFFFF00;
   localparam logic [23:0] COL_TRASH_ON  = 24'h00C000;
   localparam logic [23:0] COL_TRASH_OFF = 24'h004000;
   localparam logic [23:0] COL_ERROR     = 24'hFF00FF;
   localparam logic [23:0] COL_ROBOT     = 24'h0000FF;
   localparam logic [23:0] COL_MARKER    = 24'hFFFFFF;

endpackage

// File: rtl/tile_color_lut.sv
// -----------------------------------------------------------------------------
// tile_color_lut
// Combinational cell-code to colour lookup for the tile renderer.
// Ports:
//   code_i  [2:0]  map cell code
//   blink_i        trash blink phase; 1 selects the dim trash colour
//   rgb_o   [23:0] cell colour {R, G, B}
// -----------------------------------------------------------------------------
module tile_color_lut
   import world_pkg::*;
(
   input  logic [2:0]  code_i,
   input  logic        blink_i,
   output logic [23:0] rgb_o
);

   always_comb begin
      rgb_o = COL_ERROR;
      case (code_i)
         CELL_FREE:    rgb_o = COL_FREE;
         CELL_WALL:    rgb_o = COL_WALL;
         CELL_BARRIER: rgb_o = COL_BARRIER;
         CELL_TRASH:   rgb_o = blink_i ? COL_TRASH_OFF : COL_TRASH_ON;
         default:      rgb_o = COL_ERROR;
      endcase
   end

endmodule

// File: rtl/tile_renderer.sv
// -----------------------------------------------------------------------------
// tile_renderer
// Pixel-pipeline stage after vga_sync: maps pix_x/pix_y onto the 10x20 map,
// reads the cell code from the world store, colours it, overlays the robot
// with an orientation marker and delays the sync signals to match.
//
// There is no valid/ready handshake: every clock is a pixel beat, accepted
// unconditionally, and its colour appears exactly 3 cycles later. No stalls.
//
// Ports:
//   clock, reset          pixel clock; synchronous active-low reset
//   pix_x, pix_y  [9:0]   current pixel from vga_sync
//   video_on_in, hsync_in, vsync_in   vga_sync timing (syncs active-low)
//   robot_row, robot_column [5:0], robot_orient [1:0]  live robot state
//   map_addr      [7:0]   map read address, row*20+col (0 outside the map)
//   map_data      [2:0]   cell code, valid the cycle after map_addr
//   graph_r/g/b   [7:0]   pixel colour
//   hsync_out, vsync_out, video_on_out   timing delayed 3 cycles
// -----------------------------------------------------------------------------
module tile_renderer
   import world_pkg::*;
#(
   parameter int CELL_LOG2  = 5,
   parameter int BLINK_LOG2 = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       video_on_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [5:0] robot_row,
   input  logic [5:0] robot_column,
   input  logic [1:0] robot_orient,
   output logic [7:0] map_addr,
   input  logic [2:0] map_data,
   output logic [7:0] graph_r,
   output logic [7:0] graph_g,
   output logic [7:0] graph_b,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       video_on_out
);

   localparam int RC_W = 10 - CELL_LOG2;

   // Marker geometry relative to the cell edge: a band one quarter deep on the
   // facing side, centred over the middle quarter of the other axis.
   localparam logic [CELL_LOG2-1:0] EDGE_NEAR = CELL_LOG2'(1 << (CELL_LOG2 - 2));
   localparam logic [CELL_LOG2-1:0] EDGE_FAR  = CELL_LOG2'(3 << (CELL_LOG2 - 2));
   localparam logic [CELL_LOG2-1:0] MID_LO    = CELL_LOG2'(3 << (CELL_LOG2 - 3));
   localparam logic [CELL_LOG2-1:0] MID_HI    = CELL_LOG2'((5 << (CELL_LOG2 - 3)) - 1);

   typedef struct packed {
      logic [RC_W-1:0]      r;
      logic [RC_W-1:0]      c;
      logic [CELL_LOG2-1:0] lx;
      logic [CELL_LOG2-1:0] ly;
      logic                 in_map;
      logic                 video_on;
   } side_t;

   side_t                 s0_d, s0_q, s1_q;
   logic [7:0]            map_addr_d, map_addr_q;
   logic [2:0]            code_q;
   logic [23:0]           rgb_d, rgb_q;
   logic [2:0]            hs_q, vs_q, von_q;
   logic                  vs_prev_q;
   logic [5:0]            lat_row_q, lat_col_q;
   orient_e               lat_orient_q;
   logic [BLINK_LOG2:0]   frame_q;

   // ---------------- S0: cell coordinates and map address ----------------
   logic [9:0] row_full, col_full;
   logic [7:0] rp1, cp1;
   logic       in_map_s0;

   assign row_full  = pix_y >> CELL_LOG2;
   assign col_full  = pix_x >> CELL_LOG2;
   assign in_map_s0 = (row_full < 10'(MAP_ROWS)) && (col_full < 10'(MAP_COLS));
   // Map rows/cols are 1-based in the store; only meaningful when in_map.
   assign rp1 = row_full[7:0] + 8'd1;
   assign cp1 = col_full[7:0] + 8'd1;

   always_comb begin
      // row*20 as row*16 + row*4
      map_addr_d  = in_map_s0 ? ((rp1 << 4) + (rp1 << 2) + cp1) : 8'd0;
      s0_d.r        = row_full[RC_W-1:0];
      s0_d.c        = col_full[RC_W-1:0];
      s0_d.lx       = pix_x[CELL_LOG2-1:0];
      s0_d.ly       = pix_y[CELL_LOG2-1:0];
      s0_d.in_map   = in_map_s0;
      s0_d.video_on = video_on_in;
   end

   // ---------------- S2: colour select ----------------
   logic [23:0] lut_rgb;
   logic        robot_hit, mid_x, mid_y, marker;

   tile_color_lut u_lut (
      .code_i  (code_q),
      .blink_i (frame_q[BLINK_LOG2]),
      .rgb_o   (lut_rgb)
   );

   assign robot_hit = ((10'(s1_q.r) + 10'd1) == {4'b0, lat_row_q}) &&
                      ((10'(s1_q.c) + 10'd1) == {4'b0, lat_col_q});
   assign mid_x = (s1_q.lx >= MID_LO) && (s1_q.lx <= MID_HI);
   assign mid_y = (s1_q.ly >= MID_LO) && (s1_q.ly <= MID_HI);

   always_comb begin
      marker = 1'b0;
      case (lat_orient_q)
         ORIENT_N: marker = (s1_q.ly <  EDGE_NEAR) && mid_x;
         ORIENT_S: marker = (s1_q.ly >= EDGE_FAR)  && mid_x;
         ORIENT_E: marker = (s1_q.lx >= EDGE_FAR)  && mid_y;
         ORIENT_W: marker = (s1_q.lx <  EDGE_NEAR) && mid_y;
         default:  marker = 1'b0;
      endcase
   end

   always_comb begin
      rgb_d = COL_BLACK;
      if (!s1_q.video_on || !s1_q.in_map) begin
         rgb_d = COL_BLACK;
      end else if (robot_hit) begin
         rgb_d = marker ? COL_MARKER : COL_ROBOT;
      end else if ((s1_q.lx == '0) || (s1_q.ly == '0)) begin
         rgb_d = COL_GRID;
      end else begin
         rgb_d = lut_rgb;
      end
   end

   // Robot position and blink counter only move on a vsync falling edge so a
   // frame is never drawn with two robot positions.
   logic vs_fall;
   assign vs_fall = vs_prev_q && !vsync_in;

   always_ff @(posedge clock) begin
      if (!reset) begin
         map_addr_q   <= 8'd0;
         s0_q         <= '0;
         s1_q         <= '0;
         code_q       <= 3'd0;
         rgb_q        <= COL_BLACK;
         hs_q         <= 3'b111;
         vs_q         <= 3'b111;
         von_q        <= 3'b000;
         vs_prev_q    <= 1'b1;
         lat_row_q    <= 6'd1;
         lat_col_q    <= 6'd1;
         lat_orient_q <= ORIENT_N;
         frame_q      <= '0;
      end else begin
         map_addr_q <= map_addr_d;
         s0_q       <= s0_d;
         s1_q       <= s0_q;
         code_q     <= map_data;
         rgb_q      <= rgb_d;
         hs_q       <= {hs_q[1:0], hsync_in};
         vs_q       <= {vs_q[1:0], vsync_in};
         von_q      <= {von_q[1:0], video_on_in};
         vs_prev_q  <= vsync_in;
         if (vs_fall) begin
            lat_row_q    <= robot_row;
            lat_col_q    <= robot_column;
            lat_orient_q <= orient_e'(robot_orient);
            frame_q      <= frame_q + 1'b1;
         end
      end
   end

   assign map_addr     = map_addr_q;
   assign graph_r      = rgb_q[23:16];
   assign graph_g      = rgb_q[15:8];
   assign graph_b      = rgb_q[7:0];
   assign hsync_out    = hs_q[2];
   assign vsync_out    = vs_q[2];
   assign video_on_out = von_q[2];

endmodule

// File: tb/tb_tile_renderer.sv
module tb_tile_renderer;

   // ---------------- clock / reset / DUT ----------------
   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] pix_x, pix_y;
   logic       video_on_in, hsync_in, vsync_in;
   logic [5:0] robot_row, robot_column;
   logic [1:0] robot_orient;
   logic [7:0] map_addr;
   logic [2:0] map_data;
   logic [7:0] graph_r, graph_g, graph_b;
   logic       hsync_out, vsync_out, video_on_out;

   always #5 clock = ~clock;

   tile_renderer dut (
      .clock        (clock),
      .reset        (reset),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .video_on_in  (video_on_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .robot_row    (robot_row),
      .robot_column (robot_column),
      .robot_orient (robot_orient),
      .map_addr     (map_addr),
      .map_data     (map_data),
      .graph_r      (graph_r),
      .graph_g      (graph_g),
      .graph_b      (graph_b),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .video_on_out (video_on_out)
   );

   // World map store model: read data follows the registered address.
   logic [2:0] mem [256];
   assign map_data = mem[map_addr];

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [26:0] exp_q[$];          // {rgb, hsync, vsync, video_on}
   logic [2:0]  vld_pipe = 3'b000;
   bit          drv_active = 1'b0;
   logic [26:0] mon_e;

   // ---------------- reference model ----------------
   int m_row, m_col, m_orient, m_frame;
   bit m_vs_prev;
   bit pend_v;
   int pend_x, pend_y;
   bit pend_von, pend_hs, pend_vs;

   function automatic logic [23:0] model_rgb(int x, int y, bit von);
      int r, c, lx, ly;
      bit mx, my, mark;
      r  = y / 32;
      c  = x / 32;
      lx = x % 32;
      ly = y % 32;
      if (!von) return 24'h000000;
      if (r >= 10 || c >= 20) return 24'h000000;
      if (r + 1 == m_row && c + 1 == m_col) begin
         mx = (lx >= 12 && lx <= 19);
         my = (ly >= 12 && ly <= 19);
         case (m_orient)
            0:       mark = (ly < 8) && mx;
            1:       mark = (ly >= 24) && mx;
            2:       mark = (lx >= 24) && my;
            default: mark = (lx < 8) && my;
         endcase
         return mark ? 24'hFFFFFF : 24'h0000FF;
      end
      if (lx == 0 || ly == 0) return 24'h404040;
      case (mem[(r + 1) * 20 + c + 1])
         3'd0:    return 24'h202020;
         3'd1:    return 24'h804000;
         3'd2:    return 24'hFFFF00;
         3'd7:    return ((m_frame / 32) % 2 == 1) ? 24'h004000 : 24'h00C000;
         default: return 24'hFF00FF;
      endcase
   endfunction

   task automatic model_reset();
      m_row     = 1;
      m_col     = 1;
      m_orient  = 0;
      m_frame   = 0;
      m_vs_prev = 1'b1;
      pend_v    = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clock) begin
      if (reset !== 1'b1) vld_pipe <= 3'b000;
      else                vld_pipe <= {vld_pipe[1:0], drv_active};
   end

   always @(negedge clock) begin
      if (reset === 1'b1 && vld_pipe[2]) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: DUT output with no expected entry (t=%0t)", $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pixel", {5'b0, graph_r, graph_g, graph_b, hsync_out, vsync_out, video_on_out},
                {5'b0, mon_e});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One pixel beat. The colour of the previous beat is only known once this
   // beat's vsync has been seen, because a vsync fall here still reaches the
   // previous beat's colour stage.
   task automatic drive_cycle(input int x, input int y, input bit von, input bit hs, input bit vs);
      pix_x       = 10'(x);
      pix_y       = 10'(y);
      video_on_in = von;
      hsync_in    = hs;
      vsync_in    = vs;
      drv_active  = 1'b1;
      if (m_vs_prev && !vs) begin
         m_row    = int'(robot_row);
         m_col    = int'(robot_column);
         m_orient = int'(robot_orient);
         m_frame  = (m_frame + 1) % 64;
      end
      m_vs_prev = vs;
      if (pend_v) exp_q.push_back({model_rgb(pend_x, pend_y, pend_von), pend_hs, pend_vs, pend_von});
      pend_v   = 1'b1;
      pend_x   = x;
      pend_y   = y;
      pend_von = von;
      pend_hs  = hs;
      pend_vs  = vs;
      @(negedge clock);
   endtask

   task automatic idle();
      drive_cycle(700, 500, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic vsync_pulse();
      drive_cycle(700, 500, 1'b0, 1'b1, 1'b0);
      drive_cycle(700, 500, 1'b0, 1'b1, 1'b1);
   endtask

   // Drive one visible pixel and check the colour it produces 3 cycles later.
   task automatic probe(input string name, input int x, input int y, input logic [23:0] exp);
      drive_cycle(x, y, 1'b1, 1'b1, 1'b1);
      idle();
      idle();
      chk(name, {8'b0, graph_r, graph_g, graph_b}, {8'b0, exp});
   endtask

   // Inputs hold after the last beat, so no further vsync fall can occur.
   task automatic flush();
      if (pend_v) exp_q.push_back({model_rgb(pend_x, pend_y, pend_von), pend_hs, pend_vs, pend_von});
      pend_v     = 1'b0;
      drv_active = 1'b0;
      repeat (5) @(negedge clock);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expected entries never matched", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rgb"},      {8'b0, graph_r, graph_g, graph_b}, 32'h0);
      chk({tag, "_hsync"},    {31'b0, hsync_out}, 32'h1);
      chk({tag, "_vsync"},    {31'b0, vsync_out}, 32'h1);
      chk({tag, "_video_on"}, {31'b0, video_on_out}, 32'h0);
      chk({tag, "_map_addr"}, {24'b0, map_addr}, 32'h0);
   endtask

   task automatic random_burst(input int n);
      for (int i = 0; i < n; i++) begin
         robot_row    = 6'($urandom_range(0, 12));
         robot_column = 6'($urandom_range(0, 22));
         robot_orient = 2'($urandom_range(0, 3));
         drive_cycle($urandom_range(0, 700), $urandom_range(0, 400),
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7) != 0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 3'($urandom_range(0, 7));
      mem[45]  = 3'd1;   // row 2, col 5: wall
      mem[110] = 3'd7;   // row 5, col 10: trash
      mem[64]  = 3'd0;   // row 3, col 4: free

      reset        = 1'b0;
      pix_x        = 10'd300;
      pix_y        = 10'd100;
      video_on_in  = 1'b1;
      hsync_in     = 1'b0;
      vsync_in     = 1'b0;
      robot_row    = 6'd1;
      robot_column = 6'd1;
      robot_orient = 2'd0;
      model_reset();
      repeat (5) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b1;

      // Addressing
      drive_cycle(0, 0, 1'b1, 1'b1, 1'b1);
      chk("addr_0_0", {24'b0, map_addr}, 32'd21);
      drive_cycle(639, 319, 1'b1, 1'b1, 1'b1);
      chk("addr_639_319", {24'b0, map_addr}, 32'd220);
      drive_cycle(100, 320, 1'b1, 1'b1, 1'b1);
      chk("addr_y320", {24'b0, map_addr}, 32'd0);
      idle();
      idle();
      chk("rgb_y320", {8'b0, graph_r, graph_g, graph_b}, 32'h0);

      // Colour, grid and video blanking
      probe("wall_129_33", 129, 33, 24'h804000);
      probe("grid_128_33", 128, 33, 24'h404040);
      drive_cycle(129, 33, 1'b0, 1'b1, 1'b1);
      idle();
      idle();
      chk("video_off", {8'b0, graph_r, graph_g, graph_b}, 32'h0);

      // Blink: frame counter is 0 after reset
      probe("trash_f0", 293, 133, 24'h00C000);
      repeat (32) vsync_pulse();
      probe("trash_f32", 293, 133, 24'h004000);
      repeat (32) vsync_pulse();
      probe("trash_f64", 293, 133, 24'h00C000);

      // Robot overlay
      robot_row    = 6'd3;
      robot_column = 6'd4;
      robot_orient = 2'd2;
      vsync_pulse();
      probe("robot_marker", 120, 80, 24'hFFFFFF);
      probe("robot_body", 100, 80, 24'h0000FF);
      robot_row    = 6'd5;
      robot_column = 6'd10;
      probe("robot_no_edge", 120, 80, 24'hFFFFFF);
      vsync_pulse();
      probe("robot_moved", 120, 80, 24'h202020);

      // Randomized pixels, syncs and robot updates against the model
      random_burst(1500);
      flush();

      // Reset mid-frame forces outputs in the same cycle
      drv_active  = 1'b0;
      pix_x       = 10'd293;
      pix_y       = 10'd133;
      video_on_in = 1'b1;
      hsync_in    = 1'b0;
      vsync_in    = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("midreset");
      model_reset();
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      reset    = 1'b1;
      random_burst(300);
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
